// File: rtl/nr_recip_pkg.sv
// Shared types and helpers for the Newton-Raphson reciprocal engine.
// The helpers work at MAXW bits, so the engine supports W up to 64.
package nr_recip_pkg;

    localparam int MAXW = 128;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
`ifdef RECIP_SEED_LUT_EN
        ST_NORM = 3'd4,
`endif
        ST_SQ   = 3'd1,
        ST_MUL  = 3'd2,
        ST_HOLD = 3'd3
    } state_t;

    // 1.0 in a format with frac fractional bits
    function automatic logic [MAXW-1:0] one_q(input int frac);
        return MAXW'(1) << frac;
    endfunction

    // Clamp a signed intermediate to the unsigned range [0, 2^w-1]
    function automatic logic [MAXW-1:0] sat_uw(input logic signed [MAXW+1:0] t, input int w);
        logic [MAXW-1:0] lim;
        logic [MAXW-1:0] res;
        lim = (MAXW'(1) << w) - MAXW'(1);
        if (t < 0) begin
            res = '0;
        end else if (t > $signed({2'b00, lim})) begin
            res = lim;
        end else begin
            res = t[MAXW-1:0];
        end
        return res;
    endfunction

    // 1/d at the midpoint of bucket idx, for a normalised d in [1,2)
    function automatic logic [MAXW-1:0] seed_val(input int idx, input int sb, input int frac);
        logic [MAXW-1:0] num;
        logic [MAXW-1:0] den;
        num = one_q(frac) << (sb + 1);
        den = MAXW'((2 ** (sb + 1)) + 2 * idx + 1);
        return num / den;
    endfunction

endpackage

// File: rtl/recip_seed_lut.sv
// Seed generator: leading-one normalise D, look up 1/Dn, denormalise by the same shift.
// Purely combinational; only built when RECIP_SEED_LUT_EN is defined.
module recip_seed_lut
    import nr_recip_pkg::*;
#(
    parameter int W         = 64,
    parameter int FRAC      = 55,
    parameter int SEED_BITS = 6
) (
    input  logic [W-1:0] d_i,
    output logic [W-1:0] x0_o
);

    localparam int PW = $clog2(W);

    logic [W-1:0]         rom [2**SEED_BITS];
    logic [PW-1:0]        lead;
    logic [W-1:0]         d_norm;
    logic [SEED_BITS-1:0] idx;
    logic [W-1:0]         seed;
    logic [2*W-1:0]       up;

    for (genvar g = 0; g < 2**SEED_BITS; g++) begin : g_rom
        assign rom[g] = W'(seed_val(g, SEED_BITS, FRAC));
    end

    always_comb begin
        lead = '0;
        for (int i = 0; i < W; i++) begin
            if (d_i[i]) lead = PW'(i);
        end
    end

    assign d_norm = d_i << (PW'(W - 1) - lead);
    assign idx    = d_norm[W-2 -: SEED_BITS];
    assign seed   = rom[idx];

    always_comb begin
        up   = '0;
        x0_o = '0;
        if (int'(lead) <= FRAC) begin
            up   = {{W{1'b0}}, seed} << (FRAC - int'(lead));
            x0_o = (|up[2*W-1:W]) ? '1 : up[W-1:0];
        end else begin
            x0_o = seed >> (int'(lead) - FRAC);
        end
    end

endmodule

// File: rtl/nr_recip_iter.sv
// Newton-Raphson reciprocal, one shared WxW multiplier; result 2*ITERS cycles after accept (+1 with RECIP_SEED_LUT_EN).
// Accepts only in IDLE; result held in HOLD until out_ready_i; zero divisor returns all-ones with div_zero_o.
module nr_recip_iter
    import nr_recip_pkg::*;
#(
    parameter int W         = 64,
    parameter int FRAC      = 55,
    parameter int ITERS     = 4,
    parameter int SEED_BITS = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] d_in_i,
    input  logic [W-1:0] x0_in_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] recip_out_o,
    output logic         div_zero_o
);

    localparam logic [3:0] CNT_LAST = 4'(ITERS - 1);

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [W-1:0]   d_q, d_d, x_q, x_d, s_q, s_d, r_q, r_d;
    logic           dz_q, dz_d;

    logic [W-1:0]          mul_a, mul_b;
    logic [2*W-1:0]        prod, prod_sh;
    logic signed [MAXW+1:0] t_mul;
    logic [W-1:0]          s_new, x_new;

    // SQ squares X; MUL multiplies D by the clamped square
    assign mul_a   = (state_q == ST_SQ) ? x_q : d_q;
    assign mul_b   = (state_q == ST_SQ) ? x_q : s_q;
    assign prod    = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
    assign prod_sh = prod >> FRAC;
    assign s_new   = W'(sat_uw($signed({2'b00, MAXW'(prod_sh)}), W));
    assign t_mul   = $signed({2'b00, MAXW'({x_q, 1'b0})}) - $signed({2'b00, MAXW'(prod_sh)});
    assign x_new   = W'(sat_uw(t_mul, W));

`ifdef RECIP_SEED_LUT_EN
    logic [W-1:0] seed_x0;

    recip_seed_lut #(
        .W        (W),
        .FRAC     (FRAC),
        .SEED_BITS(SEED_BITS)
    ) u_seed (
        .d_i (d_q),
        .x0_o(seed_x0)
    );
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            d_q     <= '0;
            x_q     <= '0;
            s_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            x_q     <= x_d;
            s_q     <= s_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        x_d     = x_q;
        s_d     = s_q;
        r_d     = r_q;
        dz_d    = dz_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    d_d   = d_in_i;
                    cnt_d = '0;
                    dz_d  = 1'b0;
`ifndef RECIP_SEED_LUT_EN
                    x_d   = x0_in_i;
`endif
                    if (d_in_i == '0) begin
                        r_d     = '1;
                        dz_d    = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
`ifdef RECIP_SEED_LUT_EN
                        state_d = ST_NORM;
`else
                        state_d = ST_SQ;
`endif
                    end
                end
            end
`ifdef RECIP_SEED_LUT_EN
            ST_NORM: begin
                x_d     = seed_x0;
                state_d = ST_SQ;
            end
`endif
            ST_SQ: begin
                s_d     = s_new;
                state_d = ST_MUL;
            end
            ST_MUL: begin
                x_d   = x_new;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    r_d     = x_new;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_SQ;
                end
            end
            ST_HOLD: begin
                if (out_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready_o  = (state_q == ST_IDLE);
    assign out_valid_o = (state_q == ST_HOLD);
    assign recip_out_o = r_q;
    assign div_zero_o  = dz_q;

endmodule

// File: tb/tb_nr_recip_iter.sv
// Bench for nr_recip_iter (W=64, FRAC=55, ITERS=4, seed LUT off).
module tb_nr_recip_iter;

    localparam int W     = 64;
    localparam int FRAC  = 55;
    localparam int ITERS = 4;
    localparam logic [63:0] Q_HALF = 64'h0040_0000_0000_0000;
    localparam logic [63:0] Q_ONE  = 64'h0080_0000_0000_0000;
    localparam logic [63:0] Q_TWO  = 64'h0100_0000_0000_0000;
    localparam logic [63:0] Q_FOUR = 64'h0200_0000_0000_0000;
    localparam logic [63:0] ALL1   = 64'hFFFF_FFFF_FFFF_FFFF;
    // edges after the accepting edge until out_valid is seen
    localparam int LAT_NORM = 2 * ITERS;
    localparam int LAT_ZERO = 0;

    logic         clk, reset_n;
    logic         in_valid, in_ready, out_valid, out_ready, div_zero;
    logic [W-1:0] d_in, x0_in, recip_out;

    int nvec, nbad;

    typedef struct {
        logic [63:0] d;
        logic [63:0] x0;
        logic [63:0] r;
        logic        dz;
        int          lat;
    } vec_t;

    nr_recip_iter #(
        .W(W), .FRAC(FRAC), .ITERS(ITERS), .SEED_BITS(6)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .d_in_i     (d_in),
        .x0_in_i    (x0_in),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .recip_out_o(recip_out),
        .div_zero_o (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%h, expected 0x%h", nm, got, exp);
        end
    endtask

    // Plain-arithmetic Newton-Raphson with clamps, straight from the iteration rules
    task automatic ref_model(input logic [63:0] d, input logic [63:0] x0,
                             output logic [63:0] r, output logic dz);
        logic [63:0]         x, s;
        logic [127:0]        sq, pr;
        logic signed [129:0] t;
        if (d == 64'd0) begin
            r  = ALL1;
            dz = 1'b1;
        end else begin
            x = x0;
            for (int k = 0; k < ITERS; k++) begin
                sq = ({64'd0, x} * {64'd0, x}) >> FRAC;
                s  = (sq > {64'd0, ALL1}) ? ALL1 : sq[63:0];
                pr = ({64'd0, d} * {64'd0, s}) >> FRAC;
                t  = $signed({65'd0, x, 1'b0}) - $signed({2'b00, pr});
                if (t < 0)                            x = 64'd0;
                else if (t > $signed({66'd0, ALL1}))  x = ALL1;
                else                                  x = t[63:0];
            end
            r  = x;
            dz = 1'b0;
        end
    endtask

    task automatic do_op(input logic [63:0] d, input logic [63:0] x0, input bit rnd_ordy,
                         output logic [63:0] r, output logic dz, output int lat);
        int w;
        d_in     = d;
        x0_in    = x0;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk("in_ready_before_accept", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        d_in     = {$urandom, $urandom};
        x0_in    = {$urandom, $urandom};
        lat = 0;
        while (!out_valid && lat < 200) begin
            if (rnd_ordy) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        chk("out_valid_seen", 64'(out_valid), 64'd1);
        r  = recip_out;
        dz = div_zero;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("in_ready_after_output", 64'(in_ready), 64'd1);
    endtask

    initial begin
        vec_t        tbl[6];
        logic [63:0] r, er;
        logic        dz, edz;
        int          lat, seen;
        logic [127:0] guess;

        nvec = 0; nbad = 0;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        d_in = '0; x0_in = '0;

        tbl[0] = '{Q_TWO,   Q_HALF, Q_HALF,                 1'b0, LAT_NORM};
        tbl[1] = '{64'd0,   Q_ONE,  ALL1,                   1'b1, LAT_ZERO};
        tbl[2] = '{Q_TWO,   Q_ONE,  64'd0,                  1'b0, LAT_NORM};
        tbl[3] = '{Q_ONE,   64'h0060_0000_0000_0000, 64'h007F_FFFF_FF80_0000, 1'b0, LAT_NORM};
        tbl[4] = '{64'd1,   ALL1,   ALL1,                   1'b0, LAT_NORM};
        tbl[5] = '{Q_FOUR,  Q_ONE,  64'd0,                  1'b0, LAT_NORM};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_recip",     recip_out,      64'd0);
        chk("rst_div_zero",  64'(div_zero),  64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            do_op(tbl[i].d, tbl[i].x0, 1'b0, r, dz, lat);
            chk($sformatf("vec%0d_recip", i), r, tbl[i].r);
            chk($sformatf("vec%0d_div_zero", i), 64'(dz), 64'(tbl[i].dz));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
            if (i == 3) begin
                chk("one_within_2^24", 64'((Q_ONE - r) <= 64'd16777216), 64'd1);
            end
        end

        // Backpressure: result holds; a waiting zero divisor is taken only after the bubble
        d_in = Q_TWO; x0_in = Q_HALF; in_valid = 1'b1;
        @(posedge clk); #1;
        d_in = 64'd0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            chk("busy_in_ready_low", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_latency", 64'(lat), 64'(LAT_NORM));
        for (int k = 0; k < 5; k++) begin
            chk("bp_recip_stable", recip_out, Q_HALF);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            chk("bp_div_zero", 64'(div_zero), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("queued_zero_valid", 64'(out_valid), 64'd1);
        chk("queued_zero_recip", recip_out, ALL1);
        chk("queued_zero_div_zero", 64'(div_zero), 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset during the third MUL cycle aborts the operation
        d_in = Q_TWO; x0_in = Q_HALF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        chk("abort_no_partial", 64'(seen), 64'd0);
        do_op(Q_TWO, Q_HALF, 1'b0, r, dz, lat);
        chk("after_abort_recip", r, Q_HALF);
        chk("after_abort_latency", 64'(lat), 64'(LAT_NORM));
        chk("after_abort_div_zero", 64'(dz), 64'd0);

        // Randomised operations against the reference model
        for (int n = 0; n < 60; n++) begin
            logic [63:0] d, x0;
            case ($urandom_range(0, 3))
                0: begin
                    d  = {$urandom, $urandom} >> $urandom_range(0, 63);
                    x0 = {$urandom, $urandom} >> $urandom_range(0, 63);
                end
                1: begin
                    d = {$urandom, $urandom} >> $urandom_range(2, 40);
                    if (d == 64'd0) d = 64'd3;
                    guess = (128'd1 << (2 * FRAC)) / {64'd0, d};
                    x0 = (guess > {64'd0, ALL1}) ? ALL1 : guess[63:0];
                    x0 = x0 ^ (64'($urandom) >> $urandom_range(0, 31));
                end
                2: begin
                    d  = 64'd0;
                    x0 = {$urandom, $urandom};
                end
                default: begin
                    d  = {$urandom, $urandom};
                    x0 = {$urandom, $urandom};
                end
            endcase
            ref_model(d, x0, er, edz);
            do_op(d, x0, 1'b1, r, dz, lat);
            chk($sformatf("rnd%0d_recip d=%h x0=%h", n, d, x0), r, er);
            chk($sformatf("rnd%0d_div_zero", n), 64'(dz), 64'(edz));
            chk($sformatf("rnd%0d_latency", n), 64'(lat), 64'((d == 64'd0) ? LAT_ZERO : LAT_NORM));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
